// File: rtl/cosim_monitor_tx.sv
// Co-simulation monitor: snapshots three monitored values into a 2-deep FIFO
// and streams each one as a 12-byte framed, checksummed packet over a valid/ready byte link.
module cosim_monitor_tx #(
  parameter logic [7:0] HDR = 8'hA5
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        sample_en,
  input  logic [31:0] a0,
  input  logic [15:0] a1,
  input  logic [17:0] a2,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        tx_last,
  output logic [7:0]  drop_cnt,
  output logic        busy
);

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  // FIFO entry layout: {seq[7:0], a2[17:0], a1[15:0], a0[31:0]}
  localparam int ENTRY_W = 74;

  logic [1:0]         rst_sync;
  logic               run;
  logic [ENTRY_W-1:0] mem [2];
  logic               wr_ptr;
  logic               rd_ptr;
  logic [1:0]         count;
  logic [7:0]         seq;
  logic [7:0]         drops;
  state_t             state;
  state_t             state_nxt;
  logic [3:0]         idx;
  logic [3:0]         idx_nxt;
  logic               fire;
  logic               pop;
  logic               push;
  logic               drop;
  logic [ENTRY_W-1:0] head;
  logic [31:0]        h_a0;
  logic [15:0]        h_a1;
  logic [17:0]        h_a2;
  logic [7:0]         h_seq;
  logic [7:0]         chk;

  // Reset assertion is immediate; release is delayed two edges before captures are allowed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rst_sync <= 2'b00;
    end else begin
      rst_sync <= {rst_sync[0], 1'b1};
    end
  end

  assign run = rst_sync[1];

  assign head  = mem[rd_ptr];
  assign h_a0  = head[31:0];
  assign h_a1  = head[47:32];
  assign h_a2  = head[65:48];
  assign h_seq = head[73:66];

  assign fire = (state == SEND) && tx_ready;
  assign pop  = fire && (idx == 4'd11);
  // A full FIFO still accepts when the head frame completes on the same edge.
  assign push = run && sample_en && ((count != 2'd2) || pop);
  assign drop = run && sample_en && !push;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
      seq    <= 8'd0;
      drops  <= 8'd0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= {seq, a2, a1, a0};
        wr_ptr      <= ~wr_ptr;
        seq         <= seq + 8'd1;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
      if (drop && (drops != 8'hFF)) begin
        drops <= drops + 8'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      idx   <= 4'd0;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
    end
  end

  // Back-to-back frames only when a second entry was already queued behind the head.
  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    case (state)
      IDLE: begin
        if (count != 2'd0) begin
          state_nxt = SEND;
          idx_nxt   = 4'd0;
        end
      end
      SEND: begin
        if (fire) begin
          if (idx == 4'd11) begin
            idx_nxt   = 4'd0;
            state_nxt = (count == 2'd2) ? SEND : IDLE;
          end else begin
            idx_nxt = idx + 4'd1;
          end
        end
      end
      default: begin
        state_nxt = IDLE;
        idx_nxt   = 4'd0;
      end
    endcase
  end

  always_comb begin
    chk = HDR ^ h_seq
        ^ h_a0[7:0] ^ h_a0[15:8] ^ h_a0[23:16] ^ h_a0[31:24]
        ^ h_a1[7:0] ^ h_a1[15:8]
        ^ h_a2[7:0] ^ h_a2[15:8] ^ {6'b0, h_a2[17:16]};
  end

  // Bytes are decoded from registered state only, so they hold steady while stalled.
  always_comb begin
    tx_data = 8'h00;
    if (state == SEND) begin
      case (idx)
        4'd0:    tx_data = HDR;
        4'd1:    tx_data = h_seq;
        4'd2:    tx_data = h_a0[7:0];
        4'd3:    tx_data = h_a0[15:8];
        4'd4:    tx_data = h_a0[23:16];
        4'd5:    tx_data = h_a0[31:24];
        4'd6:    tx_data = h_a1[7:0];
        4'd7:    tx_data = h_a1[15:8];
        4'd8:    tx_data = h_a2[7:0];
        4'd9:    tx_data = h_a2[15:8];
        4'd10:   tx_data = {6'b0, h_a2[17:16]};
        4'd11:   tx_data = chk;
        default: tx_data = 8'h00;
      endcase
    end
  end

  assign tx_valid = (state == SEND);
  assign tx_last  = (state == SEND) && (idx == 4'd11);
  assign drop_cnt = drops;
  assign busy     = (count != 2'd0) || (state == SEND);

endmodule

// File: tb/tb_cosim_monitor_tx.sv
// Directed bench for cosim_monitor_tx: table of hand-computed frames plus
// sequences for backpressure, overflow, push/pop collision, wrap, saturation and reset.
module tb_cosim_monitor_tx;

  logic        clk;
  logic        rst_n;
  logic        sample_en;
  logic [31:0] a0;
  logic [15:0] a1;
  logic [17:0] a2;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        tx_last;
  logic [7:0]  drop_cnt;
  logic        busy;

  int n_checks;
  int n_fail;

  typedef struct {
    logic [31:0] a0;
    logic [15:0] a1;
    logic [17:0] a2;
    logic [95:0] exp;
  } vec_t;

  vec_t vecs [4];

  cosim_monitor_tx #(.HDR(8'hA5)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .sample_en (sample_en),
    .a0        (a0),
    .a1        (a1),
    .a2        (a2),
    .tx_data   (tx_data),
    .tx_valid  (tx_valid),
    .tx_ready  (tx_ready),
    .tx_last   (tx_last),
    .drop_cnt  (drop_cnt),
    .busy      (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected frame, byte i at bits [8*i +: 8]; checksum is the XOR of bytes 0..10.
  function automatic logic [95:0] mkFrame(input logic [31:0] v0, input logic [15:0] v1,
                                          input logic [17:0] v2, input logic [7:0] s);
    logic [95:0] f;
    logic [7:0]  x;
    f        = '0;
    f[7:0]   = 8'hA5;
    f[15:8]  = s;
    f[47:16] = v0;
    f[63:48] = v1;
    f[79:64] = v2[15:0];
    f[87:80] = {6'b0, v2[17:16]};
    x = 8'h00;
    for (int i = 0; i < 11; i++) x = x ^ f[8*i +: 8];
    f[95:88] = x;
    return f;
  endfunction

  // Called at a negedge; captures on the next rising edge and returns at the following negedge.
  task automatic applyStimulus(input logic [31:0] v0, input logic [15:0] v1, input logic [17:0] v2);
    a0 = v0;
    a1 = v1;
    a2 = v2;
    sample_en = 1'b1;
    @(negedge clk);
    sample_en = 1'b0;
  endtask

  task automatic recvFrame(input logic [95:0] exp, input int nbytes, input bit stall, input string tag);
    int idx;
    int guard;
    bit r;
    idx = 0;
    guard = 0;
    while (idx < nbytes && guard < 400) begin
      r = stall ? ($urandom_range(0, 1) != 0) : 1'b1;
      tx_ready = r;
      if (tx_valid) begin
        checkOutput({tag, "_data"}, {24'h0, tx_data}, {24'h0, exp[8*idx +: 8]});
        checkOutput({tag, "_last"}, {31'h0, tx_last}, {31'h0, (idx == 11)});
        if (r) idx++;
      end
      @(negedge clk);
      guard++;
    end
    if (idx < nbytes) begin
      n_checks++;
      n_fail++;
      $display("[TB] FAIL %s_timeout: got %0d bytes, expected %0d", tag, idx, nbytes);
    end
  endtask

  task automatic doReset();
    @(negedge clk);
    rst_n = 1'b0;
    sample_en = 1'b0;
    tx_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  initial begin
    n_checks = 0;
    n_fail = 0;
    rst_n = 1'b0;
    sample_en = 1'b0;
    tx_ready = 1'b0;
    a0 = '0;
    a1 = '0;
    a2 = '0;

    vecs[0] = '{32'h12345678, 16'hACF0, 18'h10368, 96'h9B_01_03_68_AC_F0_12_34_56_78_00_A5};
    vecs[1] = '{32'h00000000, 16'h0000, 18'h00000, 96'hA4_00_00_00_00_00_00_00_00_00_01_A5};
    vecs[2] = '{32'hFFFFFFFF, 16'hFFFF, 18'h3FFFF, 96'hA4_03_FF_FF_FF_FF_FF_FF_FF_FF_02_A5};
    vecs[3] = '{32'hDEADBEEF, 16'h1234, 18'h2ABCD, 96'hC6_02_AB_CD_12_34_DE_AD_BE_EF_03_A5};

    repeat (2) @(negedge clk);
    checkOutput("rst_valid", {31'h0, tx_valid}, 32'h0);
    checkOutput("rst_last",  {31'h0, tx_last},  32'h0);
    checkOutput("rst_data",  {24'h0, tx_data},  32'h0);
    checkOutput("rst_busy",  {31'h0, busy},     32'h0);
    checkOutput("rst_drop",  {24'h0, drop_cnt}, 32'h0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    $display("[TB] table-driven frames");
    for (int v = 0; v < 4; v++) begin
      tx_ready = 1'b1;
      applyStimulus(vecs[v].a0, vecs[v].a1, vecs[v].a2);
      checkOutput("lat_lo", {31'h0, tx_valid}, 32'h0);
      checkOutput("lat_busy", {31'h0, busy}, 32'h1);
      a0 = ~vecs[v].a0;
      a1 = ~vecs[v].a1;
      a2 = ~vecs[v].a2;
      @(negedge clk);
      checkOutput("lat_hi", {31'h0, tx_valid}, 32'h1);
      recvFrame(vecs[v].exp, 12, 1'b0, "tbl");
      checkOutput("tbl_idle", {31'h0, busy}, 32'h0);
    end

    $display("[TB] backpressure");
    doReset();
    applyStimulus(vecs[0].a0, vecs[0].a1, vecs[0].a2);
    recvFrame(vecs[0].exp, 12, 1'b1, "bp");

    $display("[TB] overflow");
    doReset();
    tx_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      a0 = 32'h1000_0000 + i;
      a1 = 16'h2000 + 16'(i);
      a2 = 18'h30000 + 18'(i);
      sample_en = 1'b1;
      @(negedge clk);
    end
    sample_en = 1'b0;
    a0 = 32'hFFFF_0000;
    checkOutput("ovf_drop", {24'h0, drop_cnt}, 32'd3);
    checkOutput("ovf_stall_valid", {31'h0, tx_valid}, 32'h1);
    checkOutput("ovf_stall_data", {24'h0, tx_data}, 32'hA5);
    recvFrame(mkFrame(32'h1000_0000, 16'h2000, 18'h30000, 8'h00), 12, 1'b0, "ovf0");
    checkOutput("ovf_nogap", {31'h0, tx_valid}, 32'h1);
    recvFrame(mkFrame(32'h1000_0001, 16'h2001, 18'h30001, 8'h01), 12, 1'b0, "ovf1");
    checkOutput("ovf_done", {31'h0, busy}, 32'h0);

    $display("[TB] reset mid-frame");
    applyStimulus(32'h0BAD_F00D, 16'h5A5A, 18'h01234);
    recvFrame(mkFrame(32'h0BAD_F00D, 16'h5A5A, 18'h01234, 8'h02), 5, 1'b0, "mr");
    checkOutput("mr_pre_valid", {31'h0, tx_valid}, 32'h1);
    rst_n = 1'b0;
    #1;
    checkOutput("mr_valid", {31'h0, tx_valid}, 32'h0);
    checkOutput("mr_last",  {31'h0, tx_last},  32'h0);
    checkOutput("mr_data",  {24'h0, tx_data},  32'h0);
    checkOutput("mr_busy",  {31'h0, busy},     32'h0);
    checkOutput("mr_drop",  {24'h0, drop_cnt}, 32'h0);
    @(negedge clk);
    tx_ready = 1'b1;
    a0 = 32'h7777_8888;
    a1 = 16'h9999;
    a2 = 18'h2AAAA;
    rst_n = 1'b1;
    sample_en = 1'b1;
    @(negedge clk);
    checkOutput("sync_edge1", {31'h0, busy}, 32'h0);
    @(negedge clk);
    @(negedge clk);
    sample_en = 1'b0;
    checkOutput("sync_edge3", {31'h0, busy}, 32'h1);
    recvFrame(mkFrame(32'h7777_8888, 16'h9999, 18'h2AAAA, 8'h00), 12, 1'b0, "mr_after");

    $display("[TB] push and pop on the same edge");
    doReset();
    tx_ready = 1'b0;
    applyStimulus(32'h1111_1111, 16'h2222, 18'h03333);
    applyStimulus(32'h4444_4444, 16'h5555, 18'h06666);
    recvFrame(mkFrame(32'h1111_1111, 16'h2222, 18'h03333, 8'h00), 11, 1'b0, "pp0");
    checkOutput("pp_last", {31'h0, tx_last}, 32'h1);
    checkOutput("pp_chk", {24'h0, tx_data},
                {24'h0, mkFrame(32'h1111_1111, 16'h2222, 18'h03333, 8'h00) >> 88});
    tx_ready = 1'b1;
    applyStimulus(32'h7777_7777, 16'h8888, 18'h09999);
    checkOutput("pp_drop", {24'h0, drop_cnt}, 32'h0);
    checkOutput("pp_nogap", {31'h0, tx_valid}, 32'h1);
    recvFrame(mkFrame(32'h4444_4444, 16'h5555, 18'h06666, 8'h01), 12, 1'b0, "pp1");
    recvFrame(mkFrame(32'h7777_7777, 16'h8888, 18'h09999, 8'h02), 12, 1'b0, "pp2");
    checkOutput("pp_done", {31'h0, busy}, 32'h0);

    $display("[TB] sequence wrap");
    doReset();
    tx_ready = 1'b1;
    for (int i = 0; i < 257; i++) begin
      applyStimulus(32'hCAFE_0000 + i, 16'(i * 3), 18'(i * 7));
      recvFrame(mkFrame(32'hCAFE_0000 + i, 16'(i * 3), 18'(i * 7), 8'(i)), 12, 1'b0, "wrap");
    end
    checkOutput("wrap_drop", {24'h0, drop_cnt}, 32'h0);

    $display("[TB] drop saturation");
    doReset();
    tx_ready = 1'b0;
    sample_en = 1'b1;
    for (int n = 1; n <= 302; n++) begin
      @(negedge clk);
      if (n == 256) checkOutput("sat_254", {24'h0, drop_cnt}, 32'd254);
      if (n == 257) checkOutput("sat_255", {24'h0, drop_cnt}, 32'd255);
      if (n == 302) checkOutput("sat_hold", {24'h0, drop_cnt}, 32'd255);
    end
    sample_en = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
